// File: rtl/sync_edge_stamp.sv
// sync_edge_stamp: multi-channel input synchroniser with per-channel edge
// detection and timestamp capture. Each channel keeps one pending event
// (timestamp + polarity) until acknowledged. A sticky overflow flag records
// edges that were dropped while an event was still pending.
module sync_edge_stamp #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TS_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        din,
  input  logic [2*NCH-1:0]      edge_mode,
  input  logic                  clear,
  input  logic [NCH-1:0]        ack,
  output logic [NCH-1:0]        sync_out,
  output logic [NCH-1:0]        evt_valid,
  output logic [NCH-1:0]        evt_pol,
  output logic [NCH*TS_W-1:0]   evt_ts,
  output logic [NCH-1:0]        ovf,
  output logic [TS_W-1:0]       ts_now
);

  // Synchroniser chain per channel; bit 0 samples the pad and the top bit
  // is the safe level.
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NCH-1:0]                  prev_q, prev_d;
  logic [NCH-1:0]                  vld_q, vld_d;
  logic [NCH-1:0]                  pol_q, pol_d;
  logic [NCH-1:0]                  ovf_q, ovf_d;
  logic [NCH-1:0][TS_W-1:0]        cap_q, cap_d;
  logic [TS_W-1:0]                 ts_q, ts_d;

  logic [NCH-1:0] lvl, rise, fall, hit;

  // Free-running timestamp; clear restarts it from zero.
  always_comb begin
    ts_d = clear ? '0 : ts_q + TS_W'(1);
  end

  // Synchroniser shift and mode-gated edge detection. prev tracks the last
  // synchronised level, so a mode change alone never looks like an edge.
  always_comb begin
    sync_d = '0;
    prev_d = '0;
    lvl    = '0;
    rise   = '0;
    fall   = '0;
    hit    = '0;
    for (int i = 0; i < NCH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], din[i]};
      lvl[i]    = sync_q[i][SYNC_STAGES-1];
      prev_d[i] = lvl[i];
      rise[i]   = lvl[i] & ~prev_q[i];
      fall[i]   = ~lvl[i] & prev_q[i];
      hit[i]    = (edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]);
    end
  end

  // Per-channel event register: clear beats everything, a hit may reload a
  // slot that is empty or being acknowledged this cycle, otherwise the first
  // edge is kept and the loss is flagged.
  always_comb begin
    vld_d = vld_q;
    pol_d = pol_q;
    ovf_d = ovf_q;
    cap_d = cap_q;
    for (int i = 0; i < NCH; i++) begin
      if (clear) begin
        vld_d[i] = 1'b0;
        ovf_d[i] = 1'b0;
      end else if (hit[i] && (!vld_q[i] || ack[i])) begin
        vld_d[i] = 1'b1;
        cap_d[i] = ts_q;
        pol_d[i] = lvl[i];
      end else if (hit[i]) begin
        ovf_d[i] = 1'b1;
      end else if (ack[i] && vld_q[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  // All state, asynchronously zeroed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      vld_q  <= '0;
      pol_q  <= '0;
      ovf_q  <= '0;
      cap_q  <= '0;
      ts_q   <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
      pol_q  <= pol_d;
      ovf_q  <= ovf_d;
      cap_q  <= cap_d;
      ts_q   <= ts_d;
    end
  end

  assign sync_out  = lvl;
  assign evt_valid = vld_q;
  assign evt_pol   = pol_q;
  assign evt_ts    = cap_q;
  assign ovf       = ovf_q;
  assign ts_now    = ts_q;

endmodule
